weight_denorm: RTL and testbench

Sequential de-normalizer for the FastICA weight path. It is the inverse of the normalizing divider. It takes a 4x4 matrix of normalized weights (fraction scaled by 2^FRAC) plus the scale factor that was divided out, and rebuilds full-scale weights as (n * scale) >>> FRAC. A single shared multiplier processes one element per cycle under a start/busy/done handshake. The results feed back into the weight-update stage.

---
 rtl/weight_denorm.sv | 193 +++++++++++++++++++
 tb/tb_weight_denorm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_denorm.sv
// Sequential de-normalizer: rebuilds full-scale weights as (n * scale) >>> FRAC,
// one element per cycle through a single shared multiplier with saturation.
module weight_denorm #(
  parameter int FRAC = 13,
  parameter int W    = 26,
  parameter int SW   = 30
) (
  input  logic                 clk_denorm,
  input  logic                 rst_n_denorm,
  input  logic                 start_denorm,
  input  logic signed [SW-1:0] scale_in,
  input  logic signed [W-1:0]  n_in11,
  input  logic signed [W-1:0]  n_in12,
  input  logic signed [W-1:0]  n_in13,
  input  logic signed [W-1:0]  n_in14,
  input  logic signed [W-1:0]  n_in21,
  input  logic signed [W-1:0]  n_in22,
  input  logic signed [W-1:0]  n_in23,
  input  logic signed [W-1:0]  n_in24,
  input  logic signed [W-1:0]  n_in31,
  input  logic signed [W-1:0]  n_in32,
  input  logic signed [W-1:0]  n_in33,
  input  logic signed [W-1:0]  n_in34,
  input  logic signed [W-1:0]  n_in41,
  input  logic signed [W-1:0]  n_in42,
  input  logic signed [W-1:0]  n_in43,
  input  logic signed [W-1:0]  n_in44,
  output logic signed [W-1:0]  w_out11,
  output logic signed [W-1:0]  w_out12,
  output logic signed [W-1:0]  w_out13,
  output logic signed [W-1:0]  w_out14,
  output logic signed [W-1:0]  w_out21,
  output logic signed [W-1:0]  w_out22,
  output logic signed [W-1:0]  w_out23,
  output logic signed [W-1:0]  w_out24,
  output logic signed [W-1:0]  w_out31,
  output logic signed [W-1:0]  w_out32,
  output logic signed [W-1:0]  w_out33,
  output logic signed [W-1:0]  w_out34,
  output logic signed [W-1:0]  w_out41,
  output logic signed [W-1:0]  w_out42,
  output logic signed [W-1:0]  w_out43,
  output logic signed [W-1:0]  w_out44,
  output logic                 busy,
  output logic                 done,
  output logic                 sat
);

  localparam int PW = W + SW;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            idx_reg, idx_next;
  logic                  done_reg, done_next;
  logic                  sat_reg, sat_next;
  logic                  capture, write_en;
  logic signed [SW-1:0]  scale_reg;
  logic signed [W-1:0]   n_vec [16];
  logic signed [W-1:0]   n_sh_reg [16];
  logic signed [W-1:0]   w_reg [16];

  logic signed [W-1:0]   n_cur;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  shifted;
  logic                  clip_hi, clip_lo, clip;
  logic signed [W-1:0]   res;

  // Row-major flattening of the matrix ports
  assign n_vec[0]  = n_in11;
  assign n_vec[1]  = n_in12;
  assign n_vec[2]  = n_in13;
  assign n_vec[3]  = n_in14;
  assign n_vec[4]  = n_in21;
  assign n_vec[5]  = n_in22;
  assign n_vec[6]  = n_in23;
  assign n_vec[7]  = n_in24;
  assign n_vec[8]  = n_in31;
  assign n_vec[9]  = n_in32;
  assign n_vec[10] = n_in33;
  assign n_vec[11] = n_in34;
  assign n_vec[12] = n_in41;
  assign n_vec[13] = n_in42;
  assign n_vec[14] = n_in43;
  assign n_vec[15] = n_in44;

  assign w_out11 = w_reg[0];
  assign w_out12 = w_reg[1];
  assign w_out13 = w_reg[2];
  assign w_out14 = w_reg[3];
  assign w_out21 = w_reg[4];
  assign w_out22 = w_reg[5];
  assign w_out23 = w_reg[6];
  assign w_out24 = w_reg[7];
  assign w_out31 = w_reg[8];
  assign w_out32 = w_reg[9];
  assign w_out33 = w_reg[10];
  assign w_out34 = w_reg[11];
  assign w_out41 = w_reg[12];
  assign w_out42 = w_reg[13];
  assign w_out43 = w_reg[14];
  assign w_out44 = w_reg[15];

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign sat  = sat_reg;

  // Full-width signed product; the arithmetic shift floors toward -inf
  assign n_cur   = n_sh_reg[idx_reg];
  assign prod    = $signed({{SW{n_cur[W-1]}}, n_cur}) * $signed({{W{scale_reg[SW-1]}}, scale_reg});
  assign shifted = prod >>> FRAC;

  // Fits in W bits only when every bit above the W-bit sign matches it
  assign clip_hi = !shifted[PW-1] && (|shifted[PW-2:W-1]);
  assign clip_lo =  shifted[PW-1] && !(&shifted[PW-2:W-1]);
  assign clip    = clip_hi || clip_lo;

  always_comb begin
    res = shifted[W-1:0];
    if (clip_hi) begin
      res = {1'b0, {(W-1){1'b1}}};
    end else if (clip_lo) begin
      res = {1'b1, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    sat_next   = sat_reg;
    capture    = 1'b0;
    write_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_denorm) begin
          capture    = 1'b1;
          sat_next   = 1'b0;
          idx_next   = 4'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        write_en = 1'b1;
        sat_next = sat_reg | clip;
        idx_next = idx_reg + 4'd1;
        if (idx_reg == 4'd15) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_denorm or negedge rst_n_denorm) begin
    if (!rst_n_denorm) begin
      state_reg <= IDLE;
      idx_reg   <= 4'd0;
      done_reg  <= 1'b0;
      sat_reg   <= 1'b0;
      scale_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
      sat_reg   <= sat_next;
      if (capture) begin
        scale_reg <= scale_in;
      end
    end
  end

  // Shadow copies decouple the job from input changes after the capture edge
  always_ff @(posedge clk_denorm or negedge rst_n_denorm) begin
    if (!rst_n_denorm) begin
      for (int i = 0; i < 16; i++) begin
        n_sh_reg[i] <= '0;
        w_reg[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (capture) begin
          n_sh_reg[i] <= n_vec[i];
        end
        if (write_en && (idx_reg == 4'(i))) begin
          w_reg[i] <= res;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_denorm.sv
// Directed bench for weight_denorm: hand-computed vectors, handshake timing,
// ignored/back-to-back starts and asynchronous reset mid-job.
module tb_weight_denorm;

  localparam int FRAC = 13;
  localparam int W    = 26;
  localparam int SW   = 30;

  logic                 clk_denorm = 1'b0;
  logic                 rst_n_denorm;
  logic                 start_denorm;
  logic signed [SW-1:0] scale_in;
  logic signed [W-1:0]  ni [16];
  logic signed [W-1:0]  wo [16];
  logic                 busy, done, sat;

  logic signed [W-1:0]  exp_w [16];
  logic                 exp_sat;
  int                   n_cmp = 0;
  int                   n_err = 0;

  always #5 clk_denorm = ~clk_denorm;

  weight_denorm #(.FRAC(FRAC), .W(W), .SW(SW)) dut (
    .clk_denorm(clk_denorm), .rst_n_denorm(rst_n_denorm), .start_denorm(start_denorm),
    .scale_in(scale_in),
    .n_in11(ni[0]),  .n_in12(ni[1]),  .n_in13(ni[2]),  .n_in14(ni[3]),
    .n_in21(ni[4]),  .n_in22(ni[5]),  .n_in23(ni[6]),  .n_in24(ni[7]),
    .n_in31(ni[8]),  .n_in32(ni[9]),  .n_in33(ni[10]), .n_in34(ni[11]),
    .n_in41(ni[12]), .n_in42(ni[13]), .n_in43(ni[14]), .n_in44(ni[15]),
    .w_out11(wo[0]),  .w_out12(wo[1]),  .w_out13(wo[2]),  .w_out14(wo[3]),
    .w_out21(wo[4]),  .w_out22(wo[5]),  .w_out23(wo[6]),  .w_out24(wo[7]),
    .w_out31(wo[8]),  .w_out32(wo[9]),  .w_out33(wo[10]), .w_out34(wo[11]),
    .w_out41(wo[12]), .w_out42(wo[13]), .w_out43(wo[14]), .w_out44(wo[15]),
    .busy(busy), .done(done), .sat(sat)
  );

  task automatic tick;
    @(posedge clk_denorm);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scramble inputs after capture so any leak from live inputs shows up
  task automatic scramble;
    scale_in = SW'($urandom);
    for (int i = 0; i < 16; i++) ni[i] = W'($urandom);
  endtask

  task automatic run_job(input string tag);
    start_denorm = 1'b1;
    tick();
    start_denorm = 1'b0;
    scramble();
    chk({tag, ":busy_T0"}, busy, 1);
    chk({tag, ":done_T0"}, done, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) chk($sformatf("%s:done_T%0d", tag, k), done, 0);
    end
    chk({tag, ":done_T16"}, done, 1);
    chk({tag, ":busy_T16"}, busy, 0);
    chk({tag, ":sat"}, sat, exp_sat);
    for (int i = 0; i < 16; i++) chk($sformatf("%s:w[%0d]", tag, i), wo[i], exp_w[i]);
    tick();
    chk({tag, ":done_T17"}, done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_denorm = 1'b0;
    start_denorm = 1'b0;
    scale_in     = '0;
    for (int i = 0; i < 16; i++) ni[i] = '0;
    tick();
    tick();
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:sat", sat, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("rst:w[%0d]", i), wo[i], 0);
    rst_n_denorm = 1'b1;
    tick();

    // 1.0 * 1000 everywhere
    scale_in = 30'sd1000;
    for (int i = 0; i < 16; i++) begin ni[i] = 26'sd8192; exp_w[i] = 26'sd1000; end
    exp_sat = 1'b0;
    run_job("unity");

    // Floor truncation on negatives
    scale_in = 30'sd1000;
    for (int i = 0; i < 16; i++) begin ni[i] = '0; exp_w[i] = '0; end
    ni[0] = 26'sd4096;  exp_w[0] = 26'sd500;
    ni[1] = -26'sd8192; exp_w[1] = -26'sd1000;
    ni[2] = 26'sd1;     exp_w[2] = 26'sd0;
    ni[3] = -26'sd1;    exp_w[3] = -26'sd1;
    exp_sat = 1'b0;
    run_job("floor");

    // Positive overflow clips to max
    scale_in = 30'sd536870911;
    for (int i = 0; i < 16; i++) begin ni[i] = '0; exp_w[i] = '0; end
    ni[0] = 26'sd33554431; exp_w[0] = 26'sd33554431;
    exp_sat = 1'b1;
    run_job("sat_pos");

    // Element order: element k lands exactly at edge Tk; later slots still hold 0
    scale_in = 30'sd3;
    for (int i = 0; i < 16; i++) ni[i] = W'(8192 * (i + 1));
    start_denorm = 1'b1;
    tick();
    start_denorm = 1'b0;
    scramble();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("order:w[%0d]_T%0d", k - 1, k), wo[k - 1], 3 * k);
      if (k < 16) chk($sformatf("order:w[%0d]_pending_T%0d", k, k), wo[k], 0);
    end
    chk("order:done", done, 1);
    chk("order:sat", sat, 0);
    tick();

    // Most-negative x most-negative: positive product, clips to max
    scale_in = -30'sd536870912;
    for (int i = 0; i < 16; i++) begin ni[i] = '0; exp_w[i] = '0; end
    ni[0] = -26'sd33554432; exp_w[0] = 26'sd33554431;
    exp_sat = 1'b1;
    run_job("sat_negneg");

    // Zero scale: all zero, sat cleared from previous job
    scale_in = '0;
    for (int i = 0; i < 16; i++) begin ni[i] = -26'sd12345 + W'(i * 777); exp_w[i] = '0; end
    exp_sat = 1'b0;
    run_job("zero_scale");

    // Start at T5 ignored; start in done cycle accepted back-to-back
    scale_in = 30'sd7;
    for (int i = 0; i < 16; i++) ni[i] = 26'sd8192;
    start_denorm = 1'b1;
    tick();
    start_denorm = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) start_denorm = 1'b1;
      tick();
      start_denorm = 1'b0;
      if (k < 16) chk($sformatf("b2b:job1_done_T%0d", k), done, 0);
    end
    chk("b2b:job1_done_T16", done, 1);
    for (int i = 0; i < 16; i++) chk($sformatf("b2b:job1_w[%0d]", i), wo[i], 7);
    scale_in = -30'sd5;
    for (int i = 0; i < 16; i++) ni[i] = 26'sd16384;
    start_denorm = 1'b1;
    tick();
    start_denorm = 1'b0;
    scramble();
    chk("b2b:job2_done_low", done, 0);
    chk("b2b:job2_busy", busy, 1);
    chk("b2b:job2_keeps_w0", wo[0], 7);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) chk($sformatf("b2b:job2_done_T%0d", k), done, 0);
    end
    chk("b2b:job2_done", done, 1);
    for (int i = 0; i < 16; i++) chk($sformatf("b2b:job2_w[%0d]", i), wo[i], -10);
    tick();
    chk("b2b:job2_done_clear", done, 0);

    // Asynchronous reset mid-job between T7 and T8
    scale_in = 30'sd1000;
    for (int i = 0; i < 16; i++) ni[i] = 26'sd8192;
    start_denorm = 1'b1;
    tick();
    start_denorm = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    chk("arst:pre_w0", wo[0], 1000);
    #3;
    rst_n_denorm = 1'b0;
    #1;
    chk("arst:busy", busy, 0);
    chk("arst:done", done, 0);
    chk("arst:sat", sat, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("arst:w[%0d]", i), wo[i], 0);
    tick();
    tick();
    #3;
    rst_n_denorm = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("arst:no_done_c%0d", k), done, 0);
    end
    chk("arst:idle_busy", busy, 0);

    scale_in = 30'sd1000;
    for (int i = 0; i < 16; i++) begin ni[i] = 26'sd8192; exp_w[i] = 26'sd1000; end
    exp_sat = 1'b0;
    run_job("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
